// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: one-entry holding register feeding a tick-paced start/data/parity/stop serialiser.
// Latency: the start bit goes out on the first tx_tick edge after acceptance; chained frames have zero gap.
// Backpressure: tx_ready is low while the holding register is full; it frees when the held byte starts its frame.
module uart_tx_ctrl #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int               CNT_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    // Byte plus the frame format it was accepted with; format is frozen per frame.
    typedef struct packed {
        logic [DATA_BITS-1:0] dat;
        logic                 par_en;
        logic                 par_odd;
        logic                 two_stop;
    } frame_t;

    state_t               state;
    frame_t               hold;
    logic                 hold_vld;
    logic                 hold_vld_nxt;
    logic [DATA_BITS-1:0] shift_dat;
    logic [CNT_W-1:0]     cnt;
    logic                 cur_par_en;
    logic                 cur_par_bit;
    logic                 cur_two_stop;
    logic                 accept;
    logic                 frame_end;
    logic                 load;

    // Handshake, end-of-frame detection and holding-register occupancy for the next edge.
    always_comb begin
        accept       = tx_valid & tx_ready;
        frame_end    = tx_tick & (((state == STOP1) & ~cur_two_stop) | (state == STOP2));
        load         = tx_tick & hold_vld & ((state == IDLE) | frame_end);
        hold_vld_nxt = hold_vld;
        if (load) begin
            hold_vld_nxt = 1'b0;
        end else if (accept) begin
            hold_vld_nxt = 1'b1;
        end
    end

    // Holding register; tx_ready is registered as the complement of next-cycle occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_vld <= 1'b0;
            tx_ready <= 1'b0;
            hold     <= '0;
        end else begin
            hold_vld <= hold_vld_nxt;
            tx_ready <= ~hold_vld_nxt;
            if (accept) begin
                hold.dat      <= tx_data;
                hold.par_en   <= parity_en;
                hold.par_odd  <= parity_odd;
                hold.two_stop <= two_stop;
            end
        end
    end

    // Frame FSM: everything advances only on tx_tick edges; tx_done is the only per-clk output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            txd          <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            shift_dat    <= '0;
            cnt          <= '0;
            cur_par_en   <= 1'b0;
            cur_par_bit  <= 1'b0;
            cur_two_stop <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            // Parity is taken from the whole latched byte before any shifting happens.
            if (load) begin
                shift_dat    <= hold.dat;
                cur_par_en   <= hold.par_en;
                cur_par_bit  <= (^hold.dat) ^ hold.par_odd;
                cur_two_stop <= hold.two_stop;
            end
            if (tx_tick) begin
                case (state)
                    IDLE: begin
                        if (hold_vld) begin
                            txd     <= 1'b0;
                            tx_busy <= 1'b1;
                            state   <= START;
                        end
                    end
                    START: begin
                        txd   <= shift_dat[0];
                        cnt   <= '0;
                        state <= DATA;
                    end
                    DATA: begin
                        if (cnt != CNT_LAST) begin
                            shift_dat <= shift_dat >> 1;
                            txd       <= shift_dat[1];
                            cnt       <= cnt + 1'b1;
                        end else if (cur_par_en) begin
                            txd   <= cur_par_bit;
                            state <= PARITY;
                        end else begin
                            txd   <= 1'b1;
                            state <= STOP1;
                        end
                    end
                    PARITY: begin
                        txd   <= 1'b1;
                        state <= STOP1;
                    end
                    STOP1, STOP2: begin
                        if ((state == STOP1) && cur_two_stop) begin
                            state <= STOP2;
                        end else begin
                            // Last stop bit ends here; a held byte starts immediately with no idle bit.
                            tx_done <= 1'b1;
                            if (hold_vld) begin
                                txd   <= 1'b0;
                                state <= START;
                            end else begin
                                txd     <= 1'b1;
                                tx_busy <= 1'b0;
                                state   <= IDLE;
                            end
                        end
                    end
                    default: begin
                        txd     <= 1'b1;
                        tx_busy <= 1'b0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: frames are queued as expected per-tick line states,
// and a monitor pops and compares them as the DUT drives each tick edge.
module tb_uart_tx_ctrl;
    typedef struct packed {
        logic txd;
        logic busy;
        logic done;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tx_tick = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       two_stop = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       txd;
    logic       tx_busy;
    logic       tx_done;

    int   checks = 0;
    int   errors = 0;
    rec_t exp_q[$];
    bit   mon_en = 1'b0;

    uart_tx_ctrl #(.DATA_BITS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_tick    (tx_tick),
        .tx_data    (tx_data),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    // One-clk tick every 16 clk, changed on the falling edge.
    initial begin : tick_gen
        int phase;
        phase = 0;
        forever begin
            @(negedge clk);
            tx_tick = (phase == 15);
            phase = (phase + 1) % 16;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached before summary, required completion");
        $fatal(1, "time limit");
    end

    // Expected line states, one record per tick edge from start bit to frame end.
    function automatic void push_frame(input logic [7:0] d, input logic pe, input logic pbit,
                                       input logic ts, input logic first_done, input logic last_end);
        exp_q.push_back({1'b0, 1'b1, first_done});
        for (int i = 0; i < 8; i++) exp_q.push_back({d[i], 1'b1, 1'b0});
        if (pe) exp_q.push_back({pbit, 1'b1, 1'b0});
        exp_q.push_back({1'b1, 1'b1, 1'b0});
        if (ts) exp_q.push_back({1'b1, 1'b1, 1'b0});
        if (last_end) exp_q.push_back({1'b1, 1'b0, 1'b1});
    endfunction

    // Monitor: compares at every tick edge where the DUT presents a frame bit or done,
    // checks idle line on other ticks and stability between ticks.
    initial begin : monitor
        rec_t r;
        logic tick_s;
        bit   prev_en;
        logic exp_txd;
        logic exp_busy;
        int   bit_idx;
        prev_en  = 1'b0;
        exp_txd  = 1'b1;
        exp_busy = 1'b0;
        bit_idx  = 0;
        forever begin
            @(posedge clk);
            tick_s = tx_tick;
            #1;
            if (!mon_en) begin
                prev_en = 1'b0;
            end else begin
                if (!prev_en) begin
                    exp_txd  = 1'b1;
                    exp_busy = 1'b0;
                    prev_en  = 1'b1;
                end
                if (tick_s && (tx_busy || tx_done)) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame_extra: got txd=%b busy=%b done=%b, required idle line", txd, tx_busy, tx_done);
                    end else begin
                        r = exp_q.pop_front();
                        bit_idx++;
                        if ({txd, tx_busy, tx_done} !== r) begin
                            errors++;
                            $display("FAIL frame_bit %0d: got txd=%b busy=%b done=%b, required txd=%b busy=%b done=%b",
                                     bit_idx, txd, tx_busy, tx_done, r.txd, r.busy, r.done);
                        end
                        exp_txd  = r.txd;
                        exp_busy = r.busy;
                    end
                end else if (tick_s) begin
                    checks++;
                    if (txd !== 1'b1) begin
                        errors++;
                        $display("FAIL idle_tick: got txd=%b, required 1", txd);
                    end
                    exp_txd  = 1'b1;
                    exp_busy = 1'b0;
                end else begin
                    checks++;
                    if (txd !== exp_txd || tx_busy !== exp_busy || tx_done !== 1'b0) begin
                        errors++;
                        $display("FAIL between_ticks: got txd=%b busy=%b done=%b, required txd=%b busy=%b done=0",
                                 txd, tx_busy, tx_done, exp_txd, exp_busy);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic po, input logic ts);
        int n;
        n = 0;
        @(negedge clk);
        tx_data    = d;
        parity_en  = pe;
        parity_odd = po;
        two_stop   = ts;
        tx_valid   = 1'b1;
        while (!tx_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk_int("send_wait_ready", (n < 400) ? 1 : 0, 1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_busy(input string name);
        int n;
        n = 0;
        while (!tx_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, tx_busy, 1'b1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk_int(name, exp_q.size(), 0);
        repeat (40) @(negedge clk);
    endtask

    initial begin : stim
        int n;
        int t_acc;
        bit seen;

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_done", tx_done, 1'b0);
        chk("rst_ready", tx_ready, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", tx_ready, 1'b1);
        mon_en = 1'b1;

        // 0x55, no parity, one stop
        push_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(8'h55, 1'b0, 1'b0, 1'b0);
        chk("t1_ready_low", tx_ready, 1'b0);
        drain("t1_drain");

        // 0x07 with even parity (bit 1), odd parity (bit 0), even + two stops
        push_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        send(8'h07, 1'b1, 1'b0, 1'b0);
        drain("t2_even_drain");
        push_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        send(8'h07, 1'b1, 1'b1, 1'b0);
        drain("t2_odd_drain");
        push_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        send(8'h07, 1'b1, 1'b0, 1'b1);
        drain("t2_two_stop_drain");

        // Back-to-back 0xA5 then 0x3C, second accepted while the first is in DATA
        push_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send(8'hA5, 1'b0, 1'b0, 1'b0);
        chk("t3_ready_before_start", tx_ready, 1'b0);
        wait_busy("t3_busy");
        repeat (20) @(negedge clk);
        chk("t3_ready_in_data", tx_ready, 1'b1);
        send(8'h3C, 1'b0, 1'b0, 1'b0);
        chk("t3_ready_held", tx_ready, 1'b0);
        drain("t3_drain");

        // Held tx_valid with tx_ready low, parity_odd changed after accept
        push_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_frame(8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        send(8'h81, 1'b0, 1'b0, 1'b0);
        wait_busy("t4_busy");
        send(8'h0F, 1'b1, 1'b0, 1'b0);
        tx_valid   = 1'b1;
        parity_odd = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (tx_ready) seen = 1'b1;
        end
        tx_valid = 1'b0;
        chk("t4_ready_seen_while_held", seen, 1'b0);
        drain("t4_drain");

        // Reset during bit 4 of 0xFF
        mon_en = 1'b0;
        send(8'hFF, 1'b0, 1'b0, 1'b0);
        wait_busy("t5_busy");
        n = 0;
        while (n < 5) begin
            @(posedge clk);
            if (tx_tick) n++;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_rst_txd", txd, 1'b1);
        chk("t5_rst_busy", tx_busy, 1'b0);
        chk("t5_rst_done", tx_done, 1'b0);
        chk("t5_rst_ready", tx_ready, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_ready_after", tx_ready, 1'b1);
        @(negedge clk);
        mon_en = 1'b1;
        repeat (70) @(negedge clk);
        chk("t5_busy_after", tx_busy, 1'b0);

        // Accept on a tick edge: start deferred to the next tick, 16 clk later
        push_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!tx_tick && n < 40);
        tx_data    = 8'h96;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        two_stop   = 1'b0;
        tx_valid   = 1'b1;
        chk("t6_ready", tx_ready, 1'b1);
        @(posedge clk);
        t_acc = 0;
        @(negedge clk);
        tx_valid = 1'b0;
        while (!tx_busy && t_acc < 100) begin
            @(posedge clk);
            #1;
            t_acc++;
        end
        chk_int("t6_start_latency", t_acc, 16);
        drain("t6_drain");

        chk_int("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
